// File: rtl/wb_stage_if.sv
// Write-back stage bus: the mem-stage result, the control inputs, the decode
// read ports and the p2 forwarding/retire outputs.
// The master drives the stage (pipeline/testbench); the slave is wb_stage.
interface wb_stage_if;
   logic [15:0] dest_reg_value_memwb_p1;
   logic [2:0]  dest_reg_index_memwb_p1;
   logic        dest_reg_write_valid_memwb_p1;
   logic        stall_memwb_p1;
   logic        flush_memwb_p1;
   logic [2:0]  rd_index_a_p0;
   logic [2:0]  rd_index_b_p0;
   logic [15:0] rd_data_a_p0;
   logic [15:0] rd_data_b_p0;
   logic        wb_valid_p2;
   logic [2:0]  wb_index_p2;
   logic [15:0] wb_value_p2;
   logic [15:0] retire_count;

   modport master (
      output dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
             dest_reg_write_valid_memwb_p1, stall_memwb_p1, flush_memwb_p1,
             rd_index_a_p0, rd_index_b_p0,
      input  rd_data_a_p0, rd_data_b_p0, wb_valid_p2, wb_index_p2,
             wb_value_p2, retire_count
   );

   modport slave (
      input  dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
             dest_reg_write_valid_memwb_p1, stall_memwb_p1, flush_memwb_p1,
             rd_index_a_p0, rd_index_b_p0,
      output rd_data_a_p0, rd_data_b_p0, wb_valid_p2, wb_index_p2,
             wb_value_p2, retire_count
   );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: p2 pipeline register, 8x16 register file with two
// combinational read ports, and a retired-write counter.
// Optional macro WB_BYPASS_EN: forwards the value being committed this cycle
// straight to a read port addressing the same index.
module wb_stage (
   input  logic       clk,
   input  logic       rst,
   wb_stage_if.slave  bus
);

   logic        valid_q, valid_d;
   logic [2:0]  index_q, index_d;
   logic [15:0] value_q, value_d;
   logic [15:0] rf_q [8];
   logic [15:0] count_q;
   logic        we;
   logic [15:0] rd_a, rd_b;

   // A held p2 entry commits only on a non-stalled edge, so it retires once.
   assign we = valid_q & ~bus.stall_memwb_p1 & ~rst;

   // p2 next state: flush clears valid only, stall holds, otherwise load.
   always_comb begin
      valid_d = valid_q;
      index_d = index_q;
      value_d = value_q;
      if (bus.flush_memwb_p1) begin
         valid_d = 1'b0;
      end else if (!bus.stall_memwb_p1) begin
         valid_d = bus.dest_reg_write_valid_memwb_p1;
         index_d = bus.dest_reg_index_memwb_p1;
         value_d = bus.dest_reg_value_memwb_p1;
      end
   end

   // State update: reset discards any pending write; commit precedes flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         index_q <= '0;
         value_q <= '0;
         count_q <= '0;
         for (int i = 0; i < 8; i++) rf_q[i] <= '0;
      end else begin
         valid_q <= valid_d;
         index_q <= index_d;
         value_q <= value_d;
         if (we) begin
            rf_q[index_q] <= value_q;
            count_q       <= count_q + 16'd1;
         end
      end
   end

   // Read ports, combinational from the decode indices.
   always_comb begin
      rd_a = rf_q[bus.rd_index_a_p0];
      rd_b = rf_q[bus.rd_index_b_p0];
`ifdef WB_BYPASS_EN
      if (we && bus.rd_index_a_p0 == index_q) rd_a = value_q;
      if (we && bus.rd_index_b_p0 == index_q) rd_b = value_q;
`endif
   end

   assign bus.rd_data_a_p0 = rd_a;
   assign bus.rd_data_b_p0 = rd_b;
   assign bus.wb_valid_p2  = valid_q;
   assign bus.wb_index_p2  = index_q;
   assign bus.wb_value_p2  = value_q;
   assign bus.retire_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: reset, a table of hand-computed cycle vectors,
// a scoreboarded random write stream, bypass, reset mid-op and count wrap.
module tb_wb_stage;

   logic clk = 1'b0;
   logic rst;
   int   n_chk  = 0;
   int   n_fail = 0;

   wb_stage_if bus ();

   wb_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [2:0]  idx;
      logic [15:0] val;
      logic        st;
      logic        fl;
      logic [2:0]  rd;
      logic        ev;
      logic [2:0]  eidx;
      logic [15:0] evl;
      logic [15:0] ecnt;
      logic [15:0] erd;
   } vec_t;

   typedef struct packed {
      logic        v;
      logic [2:0]  idx;
      logic [15:0] val;
   } p2_t;

   vec_t        tbl [13];
   p2_t         sb [$];
   p2_t         exp_p2, act_p2;
   logic [15:0] exp_rf [8];
   logic [15:0] exp_cnt;
   logic [15:0] bypass_old;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [2:0] idx, input logic [15:0] val,
                        input logic st, input logic fl);
      bus.dest_reg_write_valid_memwb_p1 = v;
      bus.dest_reg_index_memwb_p1       = idx;
      bus.dest_reg_value_memwb_p1       = val;
      bus.stall_memwb_p1                = st;
      bus.flush_memwb_p1                = fl;
   endtask

   task automatic chk_rf(input string name);
      for (int i = 0; i < 8; i++) begin
         bus.rd_index_a_p0 = 3'(i);
         bus.rd_index_b_p0 = 3'(7 - i);
         #1;
         chk({name, "_rda"}, {16'h0, bus.rd_data_a_p0}, {16'h0, exp_rf[i]});
         chk({name, "_rdb"}, {16'h0, bus.rd_data_b_p0}, {16'h0, exp_rf[7 - i]});
      end
   endtask

   initial begin
      // v idx val st fl rd | ev eidx evl ecnt erd
      tbl[0]  = '{1'b1, 3'd3, 16'hBEEF, 1'b0, 1'b0, 3'd0, 1'b1, 3'd3, 16'hBEEF, 16'd0, 16'h0000};
      tbl[1]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd0, 16'h0000, 16'd1, 16'hBEEF};
      tbl[2]  = '{1'b1, 3'd5, 16'h1234, 1'b0, 1'b0, 3'd3, 1'b1, 3'd5, 16'h1234, 16'd1, 16'hBEEF};
      tbl[3]  = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 3'd5, 1'b1, 3'd5, 16'h1234, 16'd1, 16'h0000};
      tbl[4]  = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 3'd5, 1'b1, 3'd5, 16'h1234, 16'd1, 16'h0000};
      tbl[5]  = '{1'b1, 3'd7, 16'hFFFF, 1'b1, 1'b0, 3'd5, 1'b1, 3'd5, 16'h1234, 16'd1, 16'h0000};
      tbl[6]  = '{1'b1, 3'd2, 16'h2222, 1'b0, 1'b0, 3'd5, 1'b1, 3'd2, 16'h2222, 16'd2, 16'h1234};
      tbl[7]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd2, 1'b0, 3'd2, 16'h2222, 16'd2, 16'h0000};
      tbl[8]  = '{1'b1, 3'd2, 16'h3333, 1'b0, 1'b0, 3'd3, 1'b1, 3'd2, 16'h3333, 16'd2, 16'hBEEF};
      tbl[9]  = '{1'b1, 3'd4, 16'h4444, 1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 16'h3333, 16'd3, 16'h3333};
      tbl[10] = '{1'b1, 3'd0, 16'h0F0F, 1'b0, 1'b0, 3'd2, 1'b1, 3'd0, 16'h0F0F, 16'd3, 16'h3333};
      tbl[11] = '{1'b1, 3'd1, 16'h1111, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1, 16'h1111, 16'd4, 16'h0F0F};
      tbl[12] = '{1'b0, 3'd0, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 16'h0000, 16'd5, 16'h1111};

      // Reset held for two cycles.
      rst = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      bus.rd_index_a_p0 = 3'd0;
      bus.rd_index_b_p0 = 3'd0;
      step();
      step();
      chk("rst_valid", {31'h0, bus.wb_valid_p2}, 32'h0);
      chk("rst_index", {29'h0, bus.wb_index_p2}, 32'h0);
      chk("rst_value", {16'h0, bus.wb_value_p2}, 32'h0);
      chk("rst_count", {16'h0, bus.retire_count}, 32'h0);
      for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;
      chk_rf("rst_rf");

      // Table-driven cycles: write, stall, flush+stall, flush+commit.
      rst = 1'b0;
      for (int r = 0; r < 13; r++) begin
         drive(tbl[r].v, tbl[r].idx, tbl[r].val, tbl[r].st, tbl[r].fl);
         bus.rd_index_a_p0 = tbl[r].rd;
         bus.rd_index_b_p0 = tbl[r].rd;
         step();
         exp_p2 = '{tbl[r].ev, tbl[r].eidx, tbl[r].evl};
         act_p2 = '{bus.wb_valid_p2, bus.wb_index_p2, bus.wb_value_p2};
         chk($sformatf("tbl%0d_p2", r), {12'h0, act_p2}, {12'h0, exp_p2});
         chk($sformatf("tbl%0d_cnt", r), {16'h0, bus.retire_count}, {16'h0, tbl[r].ecnt});
         chk($sformatf("tbl%0d_rda", r), {16'h0, bus.rd_data_a_p0}, {16'h0, tbl[r].erd});
         chk($sformatf("tbl%0d_rdb", r), {16'h0, bus.rd_data_b_p0}, {16'h0, tbl[r].erd});
      end
      exp_rf[0] = 16'h0F0F;
      exp_rf[1] = 16'h1111;
      exp_rf[2] = 16'h3333;
      exp_rf[3] = 16'hBEEF;
      exp_rf[5] = 16'h1234;
      exp_cnt   = 16'd5;
      chk_rf("tbl_rf");

      // Scoreboarded random stream; every valid p2 entry commits next edge.
      bus.rd_index_a_p0 = 3'd0;
      bus.rd_index_b_p0 = 3'd0;
      for (int k = 0; k < 25; k++) begin
         logic        v;
         logic [2:0]  idx;
         logic [15:0] val;
         v   = (k == 24) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
         idx = 3'($urandom_range(0, 7));
         val = 16'($urandom);
         drive(v, idx, val, 1'b0, 1'b0);
         sb.push_back('{v, idx, val});
         step();
         exp_p2 = sb.pop_front();
         act_p2 = '{bus.wb_valid_p2, bus.wb_index_p2, bus.wb_value_p2};
         chk("sb_p2", {12'h0, act_p2}, {12'h0, exp_p2});
         if (exp_p2.v) begin
            exp_rf[exp_p2.idx] = exp_p2.val;
            exp_cnt = exp_cnt + 16'd1;
         end
      end
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      step();
      chk("sb_cnt", {16'h0, bus.retire_count}, {16'h0, exp_cnt});
      chk_rf("sb_rf");

      // Bypass: read the index being committed in the same cycle.
      bypass_old = exp_rf[6];
      drive(1'b1, 3'd6, 16'hA5A5, 1'b0, 1'b0);
      step();
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      bus.rd_index_a_p0 = 3'd6;
      bus.rd_index_b_p0 = 3'd6;
      #1;
`ifdef WB_BYPASS_EN
      chk("bypass_rda", {16'h0, bus.rd_data_a_p0}, 32'hA5A5);
      chk("bypass_rdb", {16'h0, bus.rd_data_b_p0}, 32'hA5A5);
`else
      chk("bypass_rda", {16'h0, bus.rd_data_a_p0}, {16'h0, bypass_old});
      chk("bypass_rdb", {16'h0, bus.rd_data_b_p0}, {16'h0, bypass_old});
`endif
      step();
      exp_cnt = exp_cnt + 16'd1;
      chk("bypass_next_rda", {16'h0, bus.rd_data_a_p0}, 32'hA5A5);
      chk("bypass_cnt", {16'h0, bus.retire_count}, {16'h0, exp_cnt});

      // Reset while p2 holds a valid write: discarded, not committed.
      drive(1'b1, 3'd4, 16'h9999, 1'b0, 1'b0);
      step();
      chk("pre_rst_valid", {31'h0, bus.wb_valid_p2}, 32'h1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      chk("midrst_valid", {31'h0, bus.wb_valid_p2}, 32'h0);
      chk("midrst_cnt", {16'h0, bus.retire_count}, 32'h0);
      for (int i = 0; i < 8; i++) exp_rf[i] = 16'h0;
      chk_rf("midrst_rf");

      // Count wrap: 65535 commits reach 0xFFFF, one more wraps to 0.
      drive(1'b1, 3'd7, 16'h7777, 1'b0, 1'b0);
      step();
      repeat (65535) step();
      chk("wrap_ffff", {16'h0, bus.retire_count}, 32'hFFFF);
      drive(1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
      step();
      chk("wrap_zero", {16'h0, bus.retire_count}, 32'h0);
      bus.rd_index_a_p0 = 3'd7;
      #1;
      chk("wrap_rf7", {16'h0, bus.rd_data_a_p0}, 32'h7777);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 dest_reg_value_memwb_p1  input  16  result from mem stage: load data or ALU value.
REQ-004 dest_reg_index_memwb_p1  input  3  destination register index.
REQ-005 dest_reg_write_valid_memwb_p1  input  1  instruction writes a register.
REQ-006 stall_memwb_p1  input  1  hold the p2 register and suppress the register-file write.
REQ-007 flush_memwb_p1  input  1  invalidate the p2 register on the next edge.
REQ-008 rd_index_a_p0 / rd_index_b_p0  input  3 each  decode read-port indices.
REQ-009 rd_data_a_p0 / rd_data_b_p0  output  16 each  read-port data, combinational from the indices.
REQ-010 wb_valid_p2  output  1  p2 holds a valid register write.
REQ-011 wb_index_p2  output  3  p2 destination index, for EX forwarding.
REQ-012 wb_value_p2  output  16  p2 destination value, for EX forwarding.
REQ-013 retire_count  output  16  count of committed register writes.

Function
REQ-014 Edge with rst=0, flush=1: wb_valid_p2 <- 0; index/value unchanged; flush beats stall.
REQ-015 Edge with rst=0, flush=0, stall=1: p2 (valid, index, value) holds.
REQ-016 Edge with rst=0, flush=0, stall=0: p2 <- {dest_reg_write_valid_memwb_p1, dest_reg_index_memwb_p1, dest_reg_value_memwb_p1}; one-cycle latency.
REQ-017 Write enable we = wb_valid_p2 & ~stall_memwb_p1 & ~rst.
REQ-018 When we=1 at an edge: regfile[wb_index_p2] <- wb_value_p2.
REQ-019 Register file: 8 entries x 16 bits; all 8 entries writable, none hardwired.
REQ-020 A p2 entry held across N stall cycles commits exactly once, on the first non-stalled edge.
REQ-021 When flush and we are both 1 in the same cycle: the commit occurs, then p2 is invalidated.
REQ-022 Read ports are combinational with no clocked latency; both ports may address the same index.
REQ-023 retire_count increments by 1 on each edge where we=1.
REQ-024 retire_count wraps from 0xFFFF to 0x0000.
REQ-025 The write path does no width conversion: 16-bit value and 3-bit index, stored as received.

Reset
REQ-026 rst=1 at an edge sets: wb_valid_p2=0, wb_index_p2=0, wb_value_p2=0, all regfile entries=0, retire_count=0.
REQ-027 rst overrides stall and flush; a write pending in p2 when rst is asserted is discarded, not committed.
REQ-028 The edge after rst deasserts behaves per REQ-014..REQ-016.

Configuration
REQ-029 Macro WB_BYPASS_EN controls write-to-read bypass.
REQ-030 With WB_BYPASS_EN defined: when we=1 and rd_index_x_p0==wb_index_p2, rd_data_x_p0 = wb_value_p2 in the same cycle.
REQ-031 Without WB_BYPASS_EN: rd_data_x_p0 = regfile[rd_index_x_p0]; the new value is visible from the cycle after the commit edge.

Verification
REQ-032 Reset: rst=1 for 2 cycles -> all outputs 0; both read ports return 0x0000 for every index.
REQ-033 Basic write: drive valid=1, idx=3, val=0xBEEF, stall=0 -> next cycle wb_valid_p2=1, wb_index_p2=3; regfile[3]=0xBEEF after the following edge; retire_count=1.
REQ-034 Stall: p2 holds idx=5, val=0x1234; stall=1 for 3 cycles -> p2 unchanged, regfile[5] unchanged, count unchanged; stall drops -> one commit, count+1.
REQ-035 Flush: p2 valid idx=2; flush=1, stall=1 -> wb_valid_p2=0 next cycle, regfile[2] unchanged; flush=1, stall=0 -> commit, then valid=0.
REQ-036 Bypass: we=1, idx=6, val=0xA5A5, rd_index_a=6 -> rd_data_a=0xA5A5 same cycle with WB_BYPASS_EN defined; old value without it, 0xA5A5 next cycle.
REQ-037 Wrap and reset mid-operation: preload count=0xFFFF via 65535 commits, one more commit -> 0x0000; rst while p2 valid -> no commit, count=0.
